// File: rtl/cfg_lut_mux.sv
// rtl/cfg_lut_mux.sv - runtime-reprogrammable K-input truth-table function generator
module cfg_lut_mux #(
   parameter int                K    = 4,
   parameter logic [(1<<K)-1:0] INIT = '0
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [K-1:0] x,
   input  logic         in_valid,
   output logic         f,
   output logic         out_valid,
   input  logic         cfg_start,
   input  logic         cfg_valid,
   input  logic         cfg_bit,
   output logic         cfg_busy,
   output logic         cfg_done
);

   localparam int         N    = 1 << K;
   localparam logic [K:0] LAST = (K+1)'(N - 1);
   localparam logic [K:0] ONE  = (K+1)'(1);

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] LOAD = 1'b1;

   logic [0:0]   state;
   logic [K:0]   count;
   logic [N-1:0] shadow;
   logic [N-1:0] active;
   logic [N-1:0] commit_table;
   logic         accept;
   logic         commit;
   logic         f_q;
   logic         out_valid_q;
   logic         done_q;

   // A bit is taken only while loading and only when no restart is requested.
   assign accept = (state == LOAD) && !cfg_start && cfg_valid;
   assign commit = accept && (count == LAST);

   // The final bit goes straight into the committed table, bypassing the shadow.
   always_comb begin
      commit_table         = shadow;
      commit_table[N-1]    = cfg_bit;
   end

   // Registered evaluation; reads the active table as it stood before this edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         f_q         <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         out_valid_q <= in_valid;
         if (in_valid) begin
            f_q <= active[x];
         end
      end
   end

   // Load sequencer: collects serial bits into the shadow, commits atomically on the last one.
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         count  <= '0;
         shadow <= '0;
         active <= INIT;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (cfg_start) begin
                  state <= LOAD;
                  count <= '0;
               end
            end
            LOAD: begin
               if (cfg_start) begin
                  count <= '0;
               end else if (cfg_valid) begin
                  if (commit) begin
                     active <= commit_table;
                     count  <= '0;
                     state  <= IDLE;
                     done_q <= 1'b1;
                  end else begin
                     shadow[count[K-1:0]] <= cfg_bit;
                     count                <= count + ONE;
                  end
               end
            end
            default: begin
               state <= IDLE;
               count <= '0;
            end
         endcase
      end
   end

   assign f         = f_q;
   assign out_valid = out_valid_q;
   assign cfg_busy  = (state == LOAD);
   assign cfg_done  = done_q;

endmodule

// File: tb/tb_cfg_lut_mux.sv
// tb/tb_cfg_lut_mux.sv - self-checking bench for cfg_lut_mux (K=4 and K=2 instances)
module tb_cfg_lut_mux;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [3:0] x = '0;
   logic       in_valid = 1'b0;
   logic       cfg_start = 1'b0;
   logic       cfg_valid = 1'b0;
   logic       cfg_bit = 1'b0;

   logic f0, ov0, busy0, done0;
   logic f2, ov2, busy2, done2;

   int checks = 0;
   int failures = 0;
   int dcount0 = 0;
   int dcount2 = 0;

   always #5 clk = ~clk;

   cfg_lut_mux #(.K(4), .INIT(16'h0000)) dut4 (
      .clk(clk), .rst(rst), .x(x), .in_valid(in_valid),
      .f(f0), .out_valid(ov0),
      .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
      .cfg_busy(busy0), .cfg_done(done0)
   );

   cfg_lut_mux #(.K(2), .INIT(4'b1000)) dut2 (
      .clk(clk), .rst(rst), .x(x[1:0]), .in_valid(in_valid),
      .f(f2), .out_valid(ov2),
      .cfg_start(cfg_start), .cfg_valid(cfg_valid), .cfg_bit(cfg_bit),
      .cfg_busy(busy2), .cfg_done(done2)
   );

   // reference model: table as a bit array, load as "collect N accepted bits then swap"
   int   nn [2] = '{16, 4};
   logic mt [2][16];
   logic msh [2][16];
   int   mc [2];
   logic ml [2];
   logic ef [2];
   logic eov [2];
   logic edn [2];

   typedef struct {
      logic [3:0] xv;
      logic       exp_f;
   } vec_t;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic model_edge(input int id);
      logic [3:0] xi;
      xi = (id == 0) ? x : {2'b00, x[1:0]};
      if (rst) begin
         for (int i = 0; i < 16; i++) mt[id][i] = (id == 0) ? 1'b0 : (i == 3);
         ml[id] = 1'b0; mc[id] = 0; ef[id] = 1'b0; eov[id] = 1'b0; edn[id] = 1'b0;
      end else begin
         eov[id] = in_valid;
         if (in_valid) ef[id] = mt[id][xi];
         edn[id] = 1'b0;
         if (!ml[id]) begin
            if (cfg_start) begin ml[id] = 1'b1; mc[id] = 0; end
         end else if (cfg_start) begin
            mc[id] = 0;
         end else if (cfg_valid) begin
            msh[id][mc[id]] = cfg_bit;
            mc[id]++;
            if (mc[id] == nn[id]) begin
               for (int i = 0; i < nn[id]; i++) mt[id][i] = msh[id][i];
               ml[id] = 1'b0; mc[id] = 0; edn[id] = 1'b1;
            end
         end
      end
   endtask

   // one clock edge; the model predicts, outputs are sampled 1 time unit after the edge
   task automatic step();
      model_edge(0);
      model_edge(1);
      @(posedge clk);
      #1;
      chk("k4_f", f0, ef[0]);
      chk("k4_out_valid", ov0, eov[0]);
      chk("k4_busy", busy0, ml[0]);
      chk("k4_done", done0, edn[0]);
      chk("k2_f", f2, ef[1]);
      chk("k2_out_valid", ov2, eov[1]);
      chk("k2_busy", busy2, ml[1]);
      chk("k2_done", done2, edn[1]);
      dcount0 += int'(done0);
      dcount2 += int'(done2);
   endtask

   task automatic idle_inputs();
      in_valid = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_bit = 1'b0;
   endtask

   task automatic start_load();
      cfg_start = 1'b1; cfg_valid = 1'b0;
      step();
      cfg_start = 1'b0;
   endtask

   task automatic send_bits(input logic [15:0] w, input int n, input int gap);
      for (int i = 0; i < n; i++) begin
         cfg_valid = 1'b1; cfg_bit = w[i];
         step();
         cfg_valid = 1'b0;
         for (int g = 0; g < gap; g++) step();
      end
   endtask

   task automatic eval4(input logic [3:0] xv, input logic exp_f, input string name);
      x = xv; in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      chk(name, f0, exp_f);
   endtask

   initial begin
      vec_t vecs [4];
      logic [15:0] w;
      logic seen;
      logic held;

      vecs[0] = '{4'd0, 1'b1};
      vecs[1] = '{4'd2, 1'b0};
      vecs[2] = '{4'd6, 1'b1};
      vecs[3] = '{4'd15, 1'b1};

      // reset and INIT
      rst = 1'b1;
      idle_inputs();
      for (int c = 0; c < 2; c++) begin
         step();
         chk("rst_f", f0, 0);
         chk("rst_out_valid", ov0, 0);
         chk("rst_busy", busy0, 0);
      end
      rst = 1'b0;
      x = 4'd5; in_valid = 1'b1;
      step();
      chk("init_f_x5", f0, 0);
      chk("init_out_valid", ov0, 1);
      for (int v = 0; v < 4; v++) begin
         x = 4'(v); in_valid = 1'b1;
         step();
         chk("k2_init_f", f2, (v == 3) ? 1 : 0);
      end
      idle_inputs();

      // full load of A5C3
      w = 16'hA5C3;
      start_load();
      chk("load_busy_after_start", busy0, 1);
      for (int i = 0; i < 16; i++) begin
         cfg_valid = 1'b1; cfg_bit = w[i];
         step();
         chk("load_busy", busy0, (i < 15) ? 1 : 0);
         chk("load_done", done0, (i == 15) ? 1 : 0);
      end
      idle_inputs();
      for (int v = 0; v < 4; v++) eval4(vecs[v].xv, vecs[v].exp_f, "a5c3_eval");

      // evaluate x=0 every cycle while loading 0000 with 3-cycle gaps
      seen = 1'b0;
      x = 4'd0; in_valid = 1'b1;
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      for (int i = 0; i < 16; i++) begin
         for (int g = 0; g < 4; g++) begin
            cfg_valid = (g == 0); cfg_bit = 1'b0;
            step();
            if (!seen) chk("eval_old_table", f0, 1);
            else chk("eval_new_table", f0, 0);
            if (done0) seen = 1'b1;
         end
      end
      chk("eval_load_committed", seen, 1);
      idle_inputs();

      // restart mid-load
      dcount0 = 0;
      start_load();
      send_bits(16'h007F, 7, 0);
      cfg_start = 1'b1; cfg_valid = 1'b1; cfg_bit = 1'b1;
      step();
      cfg_start = 1'b0;
      send_bits(16'h0001, 16, 0);
      idle_inputs();
      step();
      chk("restart_done_count", dcount0, 1);
      for (int v = 0; v < 16; v++) eval4(4'(v), (v == 0), "restart_eval");

      // reset mid-load
      start_load();
      send_bits(16'hFFFF, 16, 0);
      dcount0 = 0;
      start_load();
      send_bits(16'h0000, 9, 0);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("midrst_busy", busy0, 0);
      step();
      chk("midrst_no_done", dcount0, 0);
      eval4(4'd3, 1'b0, "midrst_init_x3");
      start_load();
      send_bits(16'h8421, 16, 1);
      chk("midrst_reload_done", dcount0, 1);
      eval4(4'd5, 1'b1, "reload_x5");
      eval4(4'd6, 1'b0, "reload_x6");

      // idle noise
      for (int c = 0; c < 20; c++) begin
         cfg_valid = 1'($urandom_range(0, 1)); cfg_bit = 1'($urandom_range(0, 1));
         step();
         chk("noise_busy", busy0, 0);
      end
      idle_inputs();
      eval4(4'd0, 1'b1, "noise_x0");
      eval4(4'd10, 1'b1, "noise_x10");

      // out_valid pattern 1,0,1 with f holding during the gap
      x = 4'd0; in_valid = 1'b1; step();
      chk("pat_ov0", ov0, 1);
      held = f0;
      x = 4'd1; in_valid = 1'b0; step();
      chk("pat_ov1", ov0, 0);
      chk("pat_f_hold", f0, held);
      x = 4'd1; in_valid = 1'b1; step();
      chk("pat_ov2", ov0, 1);
      chk("pat_f_x1", f0, 0);
      idle_inputs();

      // K=2 commits after its 4th accepted bit
      dcount2 = 0;
      start_load();
      for (int i = 0; i < 4; i++) begin
         cfg_valid = 1'b1; cfg_bit = (i == 1 || i == 2);
         step();
         chk("k2_commit_edge", done2, (i == 3) ? 1 : 0);
      end
      idle_inputs();
      x = 4'd1; in_valid = 1'b1; step();
      chk("k2_new_x1", f2, 1);
      x = 4'd3; step();
      chk("k2_new_x3", f2, 0);
      idle_inputs();

      // randomized traffic against the model
      for (int c = 0; c < 600; c++) begin
         rst       = ($urandom_range(0, 249) == 0);
         cfg_start = ($urandom_range(0, 39) == 0);
         cfg_valid = 1'($urandom_range(0, 1));
         cfg_bit   = 1'($urandom_range(0, 1));
         in_valid  = 1'($urandom_range(0, 1));
         x         = 4'($urandom_range(0, 15));
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/cfg_lut_mux.md
Name: cfg_lut_mux

Overview:
- Parametrised, runtime-reprogrammable K-input function generator: a 2^K-entry truth table indexed by a K-bit selector.
- Generalises the fixed mux-based Boolean-function pattern used in earlier lab blocks.
- Adds a registered evaluation path and a serial configuration port.
- The new table is loaded in a shadow buffer and committed atomically; evaluation never sees a partially loaded table.

Parameters:
- K, 4, number of function inputs; table depth N = 2^K (K range 1..8).
- INIT, {2^K{1'b0}}, table contents after reset; bit i = f for input value i.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- x  input  K  function input / table index.
- in_valid  input  1  evaluate x this cycle.
- f  output  1  registered function result.
- out_valid  output  1  f is valid (one-cycle pulse per accepted evaluation).
- cfg_start  input  1  begin (or restart) a table load.
- cfg_valid  input  1  cfg_bit is valid this cycle.
- cfg_bit  input  1  serial table bit, entry 0 first.
- cfg_busy  output  1  load in progress.
- cfg_done  output  1  one-cycle pulse after a table commit.

Behaviour:
- Reset (rst=1 at a clock edge):
  - Active table <= INIT, shadow <= 0, bit counter <= 0, state <= IDLE.
  - f=0, out_valid=0, cfg_busy=0, cfg_done=0.
- Evaluation path:
  - An edge with in_valid=1 sets f <= table[x] and out_valid <= 1 (latency 1).
  - An edge with in_valid=0 sets out_valid <= 0; f holds its previous value.
  - Evaluation is independent of load state and reads the active table as it is before the edge.
- FSM, two states:
  - IDLE: cfg_busy=0; cfg_valid is ignored. cfg_start=1 -> LOAD, counter <= 0.
  - LOAD: cfg_busy=1.
    - cfg_start=1 restarts: counter <= 0, shadow contents don't-care, and that cycle's cfg_bit is not accepted. cfg_start has priority over cfg_valid.
    - Otherwise cfg_valid=1 writes shadow[counter] <= cfg_bit and increments the counter.
    - Gaps (cfg_valid=0) are allowed without limit.
  - Commit: on the edge accepting bit N-1:
    - Active table <= shadow with bit N-1 = cfg_bit.
    - Counter <= 0, state -> IDLE, cfg_done <= 1 for exactly one cycle.
- Counter is K+1 bits wide, so that a counter value equal to N is representable. The counter never exceeds N-1 in LOAD.
- cfg_start in the same cycle as a commit is not possible, because the restart takes priority and no commit occurs.
- Simultaneous evaluation and commit on the same edge: f uses the OLD table. The next evaluation uses the new table.
- cfg_start while IDLE, with cfg_valid high in the same cycle: enter LOAD; the bit is not accepted.
- rst mid-load: discards the partial shadow and restores INIT; cfg_done is not pulsed.
- cfg_busy and cfg_done are registered outputs.
  - cfg_busy rises the cycle after cfg_start is sampled.
  - cfg_busy falls in the same cycle cfg_done rises.

Test Plan:
- Reset and INIT value: K=4, INIT=0; assert rst 2 cycles, then apply in_valid=1 with x=5.
  - Required: f=0, out_valid=1 one cycle later.
  - During reset: f=0, out_valid=0, cfg_busy=0.
- Full load: cfg_start, then 16 bits of 16'hA5C3 LSB first with cfg_valid=1.
  - cfg_busy=1 from the cycle after start through the 16th bit.
  - cfg_done pulses one cycle after the 16th bit, with cfg_busy=0 in that cycle.
  - Then evaluate x=0 -> f=1, x=2 -> f=0, x=6 -> f=1, x=15 -> f=1, each one cycle after in_valid.
- Evaluate during load: with 16'hA5C3 active, load 16'h0000 with 3-cycle gaps between bits.
  - Evaluate x=0 every cycle; f=1 through and including the commit edge.
  - f=0 from the first evaluation after the commit edge.
- Restart: cfg_start, 7 bits of 1, cfg_start again (with cfg_valid=1, bit=1), then 16 bits of 16'h0001.
  - Exactly one cfg_done pulse.
  - Afterwards x=0 -> f=1 and x=1..15 -> f=0.
- Reset mid-load: with 16'hFFFF active, start a load of 16'h0000 and assert rst after 9 bits.
  - Required: cfg_busy=0, no cfg_done, table=INIT (x=3 -> f=0).
  - A subsequent full load completes normally.
- Idle noise and out_valid timing:
  - In IDLE, toggle cfg_valid and cfg_bit for 20 cycles -> table unchanged, cfg_busy stays 0.
  - Apply in_valid pattern 1,0,1 -> out_valid 1,0,1 delayed one cycle; f holds during the 0 cycle.
- K=2 instance, INIT=4'b1000: x=3 -> f=1, x=0..2 -> f=0.
  - A load of 4 bits commits after the 4th accepted bit.
